// File: rtl/filter_pkg.sv
// Shared types and default sizes for the FIR coefficient loader.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } tap_rx_state_t;

    localparam int NTAPS_DEF = 103;
    localparam int TAP_W     = 16;

endpackage

// File: rtl/tap_receiver_if.sv
// Write/read bus between the tap loader and its coefficient RAM.
interface tap_receiver_if #(
    parameter int NTAPS = 103,
    parameter int TW    = 16
);
    localparam int AW = $clog2(NTAPS);

    logic          we;
    logic [AW-1:0] waddr;
    logic [TW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic [TW-1:0] rdata;
    logic          rvalid;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output rdata, rvalid
    );

endinterface

// File: rtl/tap_ram.sv
// NTAPS x TW coefficient store: one write port, one registered read port.
module tap_ram #(
    parameter int NTAPS = 103,
    parameter int TW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tap_receiver_if.slave bus
);

    logic [TW-1:0] mem [NTAPS];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Non-blocking read of mem gives old data on a same-index write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.re;
            if (bus.re) begin
                if (32'(bus.raddr) < NTAPS) begin
                    bus.rdata <= mem[bus.raddr];
                end else begin
                    bus.rdata <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/tap_receiver.sv
// FIR tap loader: sequential coefficient capture with read-back port.
// Optional running checksum enabled by TAP_RECEIVER_CHECKSUM_EN.
module tap_receiver
    import filter_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int TW    = TAP_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_tap_wr,
    input  logic [TW-1:0]              i_tap,
    input  logic                       i_clear,
    input  logic                       i_rd_en,
    input  logic [$clog2(NTAPS)-1:0]   i_rd_idx,
    output logic [TW-1:0]              o_rd_tap,
    output logic                       o_rd_valid,
    output logic                       o_load_done,
    output logic [$clog2(NTAPS+1)-1:0] o_tap_count,
    output logic                       o_overflow,
    output logic [23:0]                o_checksum
);

    localparam int AW = $clog2(NTAPS);
    localparam int CW = $clog2(NTAPS + 1);

    tap_rx_state_t state_q, state_n;
    logic [CW-1:0] count_q, count_n;
    logic          ovf_q, ovf_n;
    logic          done_q;
    logic          accept;

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        ovf_n   = ovf_q;
        accept  = 1'b0;
        if (i_clear) begin
            state_n = IDLE;
            count_n = '0;
            ovf_n   = 1'b0;
        end else if (i_tap_wr) begin
            unique case (state_q)
                IDLE, LOAD: begin
                    accept  = 1'b1;
                    count_n = count_q + CW'(1);
                    state_n = (count_n == CW'(NTAPS)) ? FULL : LOAD;
                end
                FULL:    ovf_n = 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            ovf_q   <= ovf_n;
            done_q  <= (state_n == FULL);
        end
    end

`ifdef TAP_RECEIVER_CHECKSUM_EN
    logic [23:0] csum_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + 24'(i_tap);
        end
    end

    assign o_checksum = csum_q;
`else
    assign o_checksum = '0;
`endif

    tap_receiver_if #(.NTAPS(NTAPS), .TW(TW)) ram_bus ();

    // Count doubles as the write index; it is 0 whenever IDLE.
    assign ram_bus.we    = accept;
    assign ram_bus.waddr = AW'(count_q);
    assign ram_bus.wdata = i_tap;
    assign ram_bus.re    = i_rd_en;
    assign ram_bus.raddr = i_rd_idx;

    tap_ram #(.NTAPS(NTAPS), .TW(TW)) u_ram (
        .clk   (i_clk),
        .rst_n (i_reset),
        .bus   (ram_bus.slave)
    );

    assign o_rd_tap    = ram_bus.rdata;
    assign o_rd_valid  = ram_bus.rvalid;
    assign o_load_done = done_q;
    assign o_tap_count = count_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_tap_receiver.sv
// Scoreboard bench for tap_receiver: directed load scenarios plus random traffic.
module tb_tap_receiver;
    import filter_pkg::*;

    localparam int N  = NTAPS_DEF;
    localparam int W  = TAP_W;
    localparam int CW = $clog2(N + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] tap_count;
    logic          done;
    logic          ovf;
    logic [23:0]   csum;

    tap_receiver_if #(.NTAPS(N), .TW(W)) bus ();

    always #5 clk = ~clk;

    tap_receiver #(.NTAPS(N), .TW(W)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_tap_wr    (bus.we),
        .i_tap       (bus.wdata),
        .i_clear     (clear),
        .i_rd_en     (bus.re),
        .i_rd_idx    (bus.raddr),
        .o_rd_tap    (bus.rdata),
        .o_rd_valid  (bus.rvalid),
        .o_load_done (done),
        .o_tap_count (tap_count),
        .o_overflow  (ovf),
        .o_checksum  (csum)
    );

    // Reference model: what the loader should hold, by plain arithmetic.
    int          mem_m [N];
    bit          known [N];
    int          cnt_m;
    bit          ovf_m;
    int          sum_m;
    logic [W-1:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    function automatic int csum_exp();
`ifdef TAP_RECEIVER_CHECKSUM_EN
        return sum_m;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no read");
            end else begin
                e = exp_q.pop_front();
                if (bus.rdata !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", bus.rdata, e);
                end
            end
        end
    end

    task automatic step(input bit wr, input int d, input bit clr,
                        input bit rd, input int idx, input bit rst);
        bit rd_go;
        rd_go     = rd && rst;
        rst_n     = rst;
        clear     = clr;
        bus.we    = wr;
        bus.wdata = W'(d);
        bus.re    = rd_go;
        bus.raddr = 7'(idx);
        if (rd_go) begin
            if (idx >= N) exp_q.push_back('0);
            else          exp_q.push_back(W'(mem_m[idx]));
        end
        @(posedge clk);
        if (!rst || clr) begin
            cnt_m = 0;
            ovf_m = 0;
            sum_m = 0;
        end else if (wr) begin
            if (cnt_m == N) begin
                ovf_m = 1;
            end else begin
                mem_m[cnt_m] = d & 32'hFFFF;
                known[cnt_m] = 1;
                cnt_m++;
                sum_m = (sum_m + (d & 32'hFFFF)) & 32'hFF_FFFF;
            end
        end
        #1;
        chk("count", 32'(tap_count), cnt_m);
        chk("done", 32'(done), 32'(cnt_m == N));
        chk("overflow", 32'(ovf), 32'(ovf_m));
        chk("checksum", 32'(csum), csum_exp());
        chk("rd_valid", 32'(bus.rvalid), 32'(rd_go));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int idx;
        bus.we    = 0;
        bus.wdata = '0;
        bus.re    = 0;
        bus.raddr = '0;
        bus.waddr = '0;
        cnt_m = 0;
        ovf_m = 0;
        sum_m = 0;
        for (int i = 0; i < N; i++) known[i] = 0;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_rd_tap", 32'(bus.rdata), 0);

        for (int i = 1; i <= N; i++) begin
            if ($urandom_range(3) == 0) idle();
            step(1, i, 0, 0, 0, 1);
        end
        chk("load_done", 32'(done), 1);
        chk("load_count", 32'(tap_count), N);
`ifdef TAP_RECEIVER_CHECKSUM_EN
        chk("checksum_load", 32'(csum), 32'h14EC);
`else
        chk("checksum_load", 32'(csum), 0);
`endif

        step(0, 0, 0, 1, 5, 1);
        step(0, 0, 0, 1, 110, 1);
        step(1, 'hBEEF, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("ovf_sticky", 32'(ovf), 1);

        step(1, 'hAAAA, 1, 0, 0, 1);
        step(1, 'h1234, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("clear_count", 32'(tap_count), 1);
        step(1, 'h5555, 0, 1, 1, 1);
        idle();

        while (cnt_m < 50) step(1, $urandom, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_mid_count", 32'(tap_count), 0);
        for (int i = 0; i < N; i++) step(1, $urandom, 0, 0, 0, 1);
        chk("reload_done", 32'(done), 1);
        step(0, 0, 0, 1, 0, 1);

        for (int n = 0; n < 700; n++) begin
            idx = $urandom_range(127);
            step($urandom_range(1),
                 $urandom,
                 $urandom_range(39) == 0,
                 (idx >= N) || known[idx],
                 idx,
                 $urandom_range(149) != 0);
        end

        idle();
        idle();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
